cpu_code_loader: RTL and testbench
==================================

Name: cpu_code_loader

Overview:
- Upstream boot stage for the embedded stack CPU.
- Accepts a code image from the host word-serial interface with a valid/ready handshake and buffers it internally.
- Then drives the CPU's two-bit reset/phase vector: a contiguous one-word-per-clock LOAD burst on the CPU's 16-bit parallel input, followed by a boot_done pulse and the RUN phase.
- Exists because the CPU advances its load address every clock while LOAD is high, so the host cannot feed it directly.

Parameters:
- IMAGE_WORDS, 1024, number of 16-bit words loaded; fills the lower half of the 2k code memory. Legal range 2..1024.
- CNT_W, 11, width of the word counters; must satisfy 2**CNT_W > IMAGE_WORDS.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse: arm a new load. Honoured in IDLE, RUN and ERROR; ignored in FILL, BURST and DONE.
- s_valid  in  1  host word valid.
- s_data  in  16  host word.
- s_ready  out  1  loader accepts s_data this cycle; a transfer is s_valid && s_ready.
- par  out  16  CPU parallel/code-write input.
- cpu_rst  out  2 [2:1]  CPU phase vector; bit 1 = LOAD, bit 2 = RUN.
- boot_done  out  1  one-cycle pulse that resets the CPU pc to 0.
- busy  out  1  high in FILL, BURST and DONE.
- err  out  1  sticky error flag.
- word_cnt  out  CNT_W  number of words accepted in the current FILL.

Behaviour:
- Reset values: s_ready=0, par=16'h8000 (nop), cpu_rst=2'b00, boot_done=0, busy=0, err=0, word_cnt=0, state=IDLE.
- Image buffer: IMAGE_WORDS x 16 synchronous RAM, 1-cycle read latency.
- IDLE:
  - cpu_rst=00, par=16'h8000.
  - start -> FILL; clears word_cnt and err.
- FILL:
  - s_ready=1.
  - Each transfer writes buf[word_cnt] and increments word_cnt.
  - The transfer of word IMAGE_WORDS-1 moves to BURST on the next clock; s_ready drops in that same next cycle.
  - There is no timeout; the loader waits for the host indefinitely.
  - cpu_rst stays 00 throughout FILL.
- BURST:
  - The first buffer read is issued on the FILL->BURST transition so that par is valid on the first LOAD cycle.
  - cpu_rst=2'b01 for exactly IMAGE_WORDS consecutive clocks.
  - During the k-th LOAD clock (k=0..IMAGE_WORDS-1), par=buf[k], with no bubbles.
  - After the last LOAD clock -> DONE.
- DONE (one clock):
  - cpu_rst=2'b10, boot_done=1, par=16'h8000.
  - Then -> RUN.
- RUN:
  - cpu_rst=2'b10, boot_done=0, par=16'h8000, s_ready=0.
  - start -> FILL with cpu_rst=00 in the next cycle, which halts the CPU.
- ERROR: see Optional Feature.
- Output timing: all outputs are registered; cpu_rst, par and boot_done change only on clk edges.
- Host words presented outside FILL are not accepted (s_ready=0) and are never written.
- Async rst in any state:
  - All outputs return to their reset values immediately; state -> IDLE.
  - A partial image is discarded, and any partial burst is abandoned with cpu_rst=00.
- start coincident with a transfer in RUN: FILL begins and that word is not accepted; the host re-presents it.

Optional Feature:
- Macro: CPU_LOADER_CKSUM_EN.
- When defined:
  - FILL accepts IMAGE_WORDS+1 words; the last one is a checksum and is not stored in buf.
  - The 16-bit sum modulo 2^16 of the image words must equal the checksum.
  - Match -> BURST as normal.
  - Mismatch -> ERROR: err=1, cpu_rst=00, no LOAD cycles issued. ERROR is left only by start (-> FILL) or rst.
  - word_cnt counts the checksum word too.
- When undefined:
  - No checksum word; ERROR is unreachable and err stays 0.

Test Plan:
- rst, then start, then 1024 words with s_valid held high and value = index -> s_ready stays high for exactly 1024 cycles. Then cpu_rst=01 for exactly 1024 clocks with par=0,1,...,1023 in order, then one cycle of cpu_rst=10 with boot_done=1, then cpu_rst=10 held.
- Host stalls with random s_valid gaps during FILL -> the LOAD burst is still contiguous with no repeated or skipped words; word_cnt equals the number of accepted words at each point.
- Assert rst in the middle of the burst (after 500 LOAD cycles) -> cpu_rst=00, par=16'h8000 and busy=0 immediately. A subsequent start reloads the full image.
- start pulses during FILL and BURST -> ignored; burst length stays 1024. A start in RUN -> cpu_rst=00 next cycle and s_ready=1.
- With CPU_LOADER_CKSUM_EN: correct checksum -> normal burst. Checksum off by 1 -> err=1, no cpu_rst=01 cycle, state ERROR until start.
- With IMAGE_WORDS=2 (boundary) -> exactly 2 LOAD cycles with par=buf[0], buf[1], then the boot_done pulse.

Source files
------------

// File: rtl/cpu_code_loader.sv
// cpu_code_loader: boot stage for the embedded stack CPU.
// The host delivers a code image word-serially over a valid/ready handshake.
// The image is held in an internal buffer, then replayed to the CPU as a
// gap-free one-word-per-clock LOAD burst, followed by a boot_done pulse and RUN.
// Optional build macro: CPU_LOADER_CKSUM_EN adds a trailing checksum word.
// A checksum mismatch parks the loader in ERROR with no LOAD cycles issued.
module cpu_code_loader #(
    parameter int unsigned IMAGE_WORDS = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [15:0]      s_data,
    output logic             s_ready,
    output logic [15:0]      par,
    output logic [2:1]       cpu_rst,
    output logic             boot_done,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int unsigned      ADDR_W   = (IMAGE_WORDS > 1) ? $clog2(IMAGE_WORDS) : 1;
    localparam logic [15:0]      NOP      = 16'h8000;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMAGE_WORDS - 1);
`ifdef CPU_LOADER_CKSUM_EN
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(IMAGE_WORDS);
`else
    localparam logic [CNT_W-1:0] FILL_LAST = LAST_IDX;
`endif

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        BURST,
        DONE,
        RUN,
        ERROR
    } state_t;

    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] rd_addr_c;
    logic             take_c;
    logic             arm_c;
    logic             wr_c;
    logic [15:0]      mem [IMAGE_WORDS];
`ifdef CPU_LOADER_CKSUM_EN
    logic [15:0]      sum_q;
`endif

    // Next-state decode, handshake qualification and burst read address
    always_comb begin
        state_n   = state_q;
        take_c    = 1'b0;
        arm_c     = 1'b0;
        wr_c      = 1'b0;
        rd_addr_c = '0;
        case (state_q)
            IDLE, RUN, ERROR: begin
                if (start) begin
                    state_n = FILL;
                    arm_c   = 1'b1;
                end
            end
            FILL: begin
                take_c = s_valid && s_ready;
`ifdef CPU_LOADER_CKSUM_EN
                wr_c = take_c && (word_cnt != FILL_LAST);
                if (take_c && (word_cnt == FILL_LAST)) begin
                    state_n = (s_data == sum_q) ? BURST : ERROR;
                end
`else
                wr_c = take_c;
                if (take_c && (word_cnt == FILL_LAST)) begin
                    state_n = BURST;
                end
`endif
            end
            BURST: begin
                // Read one word ahead so par holds buf[k] during LOAD clock k
                rd_addr_c = burst_cnt + CNT_W'(1);
                if (burst_cnt == LAST_IDX) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = RUN;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register and word/burst counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            word_cnt  <= '0;
            burst_cnt <= '0;
`ifdef CPU_LOADER_CKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q <= state_n;
            if (arm_c) begin
                word_cnt <= '0;
            end else if (take_c) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (state_q == BURST) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
                burst_cnt <= '0;
            end
`ifdef CPU_LOADER_CKSUM_EN
            if (arm_c) begin
                sum_q <= '0;
            end else if (wr_c) begin
                sum_q <= sum_q + s_data;
            end
`endif
        end
    end

    // Image buffer write port
    always_ff @(posedge clk) begin
        if (wr_c) begin
            mem[ADDR_W'(word_cnt)] <= s_data;
        end
    end

    // Registered outputs, decoded from the upcoming state; par is the buffer read register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready   <= 1'b0;
            par       <= NOP;
            cpu_rst   <= 2'b00;
            boot_done <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            s_ready   <= (state_n == FILL);
            boot_done <= (state_n == DONE);
            busy      <= (state_n == FILL) || (state_n == BURST) || (state_n == DONE);
            err       <= (state_n == ERROR);
            case (state_n)
                BURST:     cpu_rst <= 2'b01;
                DONE, RUN: cpu_rst <= 2'b10;
                default:   cpu_rst <= 2'b00;
            endcase
            if (state_n == BURST) begin
                par <= mem[ADDR_W'(rd_addr_c)];
            end else begin
                par <= NOP;
            end
        end
    end

endmodule

// File: tb/tb_cpu_code_loader.sv
// Directed testbench for cpu_code_loader: a full-size instance (1024 words)
// and a minimum-size instance (2 words). Checksum scenarios are compiled in
// when CPU_LOADER_CKSUM_EN is defined.
module tb_cpu_code_loader;

    localparam int N   = 1024;
    localparam int CW  = 11;
    localparam int NS  = 2;
    localparam int CWS = 2;
`ifdef CPU_LOADER_CKSUM_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [15:0]   s_data = 16'h0;
    logic          s_ready;
    logic [15:0]   par;
    logic [2:1]    cpu_rst;
    logic          boot_done;
    logic          busy;
    logic          err;
    logic [CW-1:0] word_cnt;

    logic           start_s = 1'b0;
    logic           s_valid_s = 1'b0;
    logic [15:0]    s_data_s = 16'h0;
    logic           s_ready_s;
    logic [15:0]    par_s;
    logic [2:1]     cpu_rst_s;
    logic           boot_done_s;
    logic           busy_s;
    logic           err_s;
    logic [CWS-1:0] word_cnt_s;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] img [N];

    cpu_code_loader #(.IMAGE_WORDS(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .par(par), .cpu_rst(cpu_rst), .boot_done(boot_done),
        .busy(busy), .err(err), .word_cnt(word_cnt)
    );

    cpu_code_loader #(.IMAGE_WORDS(NS), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .s_valid(s_valid_s), .s_data(s_data_s),
        .s_ready(s_ready_s), .par(par_s), .cpu_rst(cpu_rst_s), .boot_done(boot_done_s),
        .busy(busy_s), .err(err_s), .word_cnt(word_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse and confirm FILL has been entered
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if ({s_ready, busy, cpu_rst, err, word_cnt} !== {1'b1, 1'b1, 2'b00, 1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL start_enter_fill: got ready=%b busy=%b cpu_rst=%b err=%b word_cnt=%0d, want 1 1 00 0 0",
                     s_ready, busy, cpu_rst, err, word_cnt);
        end
    endtask

    // Feed the image (plus checksum word when enabled), optionally with valid gaps
    task automatic fill_big(input bit gaps, input bit bad_sum, input int start_at);
        logic [15:0] sum;
        int idx;
        int cyc;
        sum = 16'h0;
        for (int i = 0; i < N; i++) sum = sum + img[i];
        idx = 0;
        cyc = 0;
        while (idx < N + EXTRA && cyc < 8000) begin
            s_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!s_valid)     s_data = 16'hdead;
            else if (idx < N) s_data = img[idx];
            else              s_data = bad_sum ? 16'(sum + 16'd1) : sum;
            start = (idx == start_at);
            n_checks++;
            if (s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready idx=%0d: got %b, want 1", idx, s_ready);
            end
            step();
            cyc++;
            if (s_valid) idx++;
            n_checks++;
            if (word_cnt !== CW'(idx)) begin
                n_fail++;
                $display("FAIL fill_word_cnt: got %0d, want %0d", word_cnt, idx);
            end
        end
        s_valid = 1'b0;
        start = 1'b0;
        n_checks++;
        if (idx != N + EXTRA) begin
            n_fail++;
            $display("FAIL fill_budget: accepted %0d words, want %0d", idx, N + EXTRA);
        end
        if (!gaps) begin
            n_checks++;
            if (cyc != N + EXTRA) begin
                n_fail++;
                $display("FAIL fill_ready_cycles: got %0d, want %0d", cyc, N + EXTRA);
            end
        end
    endtask

    // Check lim LOAD cycles; for a full burst also check DONE and RUN
    task automatic burst_big(input int lim, input int start_at);
        for (int k = 0; k < lim; k++) begin
            n_checks++;
            if ({cpu_rst, par, s_ready, busy, boot_done} !== {2'b01, img[k], 3'b010}) begin
                n_fail++;
                $display("FAIL burst_word k=%0d: got cpu_rst=%b par=%h rdy/busy/done=%b%b%b, want 01 %h 010",
                         k, cpu_rst, par, s_ready, busy, boot_done, img[k]);
            end
            start = (k == start_at);
            step();
        end
        start = 1'b0;
        if (lim == N) begin
            n_checks++;
            if ({cpu_rst, par, boot_done, busy, err} !== {2'b10, 16'h8000, 3'b110}) begin
                n_fail++;
                $display("FAIL done_cycle: got cpu_rst=%b par=%h done/busy/err=%b%b%b, want 10 8000 110",
                         cpu_rst, par, boot_done, busy, err);
            end
            step();
            n_checks++;
            if ({cpu_rst, par, boot_done, busy, s_ready, err} !== {2'b10, 16'h8000, 4'b0000}) begin
                n_fail++;
                $display("FAIL run_state: got cpu_rst=%b par=%h done/busy/rdy/err=%b%b%b%b, want 10 8000 0000",
                         cpu_rst, par, boot_done, busy, s_ready, err);
            end
        end
    endtask

    task automatic test_reset();
        s_valid = 1'b1;
        s_data  = 16'h1111;
        #2 rst = 1'b1;
        step();
        n_checks++;
        if ({s_ready, par, cpu_rst, boot_done, busy, err, word_cnt} !== {1'b0, 16'h8000, 2'b00, 3'b000, CW'(0)}) begin
            n_fail++;
            $display("FAIL reset_big: got rdy=%b par=%h cpu_rst=%b done/busy/err=%b%b%b cnt=%0d, want 0 8000 00 000 0",
                     s_ready, par, cpu_rst, boot_done, busy, err, word_cnt);
        end
        n_checks++;
        if ({s_ready_s, par_s, cpu_rst_s, boot_done_s, busy_s, err_s, word_cnt_s} !== {1'b0, 16'h8000, 2'b00, 3'b000, CWS'(0)}) begin
            n_fail++;
            $display("FAIL reset_small: got rdy=%b par=%h cpu_rst=%b done/busy/err=%b%b%b cnt=%0d, want 0 8000 00 000 0",
                     s_ready_s, par_s, cpu_rst_s, boot_done_s, busy_s, err_s, word_cnt_s);
        end
        rst = 1'b0;
        step();
        step();
        n_checks++;
        if ({s_ready, word_cnt, cpu_rst, busy} !== {1'b0, CW'(0), 2'b00, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_ignores_host: got rdy=%b cnt=%0d cpu_rst=%b busy=%b, want 0 0 00 0",
                     s_ready, word_cnt, cpu_rst, busy);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_full_load();
        for (int i = 0; i < N; i++) img[i] = 16'(i);
        do_start();
        fill_big(1'b0, 1'b0, -1);
        burst_big(N, -1);
    endtask

    // start in RUN with a word on the bus: that word is dropped, CPU is halted
    task automatic test_run_restart_stall();
        s_valid = 1'b1;
        s_data  = 16'hbeef;
        start   = 1'b1;
        step();
        start   = 1'b0;
        n_checks++;
        if ({cpu_rst, s_ready, busy, word_cnt} !== {2'b00, 1'b1, 1'b1, CW'(0)}) begin
            n_fail++;
            $display("FAIL run_restart: got cpu_rst=%b rdy=%b busy=%b cnt=%0d, want 00 1 1 0",
                     cpu_rst, s_ready, busy, word_cnt);
        end
        for (int i = 0; i < N; i++) img[i] = 16'(i * 37) ^ 16'h5a5a;
        fill_big(1'b1, 1'b0, -1);
        burst_big(N, -1);
    endtask

    task automatic test_ignore_start();
        for (int i = 0; i < N; i++) img[i] = ~16'(i * 3);
        do_start();
        fill_big(1'b0, 1'b0, 300);
        burst_big(N, 100);
    endtask

    task automatic test_rst_mid_burst();
        for (int i = 0; i < N; i++) img[i] = 16'(i) ^ 16'hc3c3;
        do_start();
        fill_big(1'b0, 1'b0, -1);
        burst_big(500, -1);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({cpu_rst, par, busy, s_ready, boot_done} !== {2'b00, 16'h8000, 3'b000}) begin
            n_fail++;
            $display("FAIL rst_mid_burst: got cpu_rst=%b par=%h busy/rdy/done=%b%b%b, want 00 8000 000",
                     cpu_rst, par, busy, s_ready, boot_done);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        n_checks++;
        if ({cpu_rst, busy, word_cnt} !== {2'b00, 1'b0, CW'(0)}) begin
            n_fail++;
            $display("FAIL after_rst_idle: got cpu_rst=%b busy=%b cnt=%0d, want 00 0 0", cpu_rst, busy, word_cnt);
        end
        for (int i = 0; i < N; i++) img[i] = 16'(N - i);
        do_start();
        fill_big(1'b0, 1'b0, -1);
        burst_big(N, -1);
    endtask

`ifdef CPU_LOADER_CKSUM_EN
    task automatic test_cksum_error();
        for (int i = 0; i < N; i++) img[i] = 16'(i * 11 + 5);
        do_start();
        fill_big(1'b0, 1'b1, -1);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({err, cpu_rst, busy, s_ready, boot_done} !== {1'b1, 2'b00, 3'b000}) begin
                n_fail++;
                $display("FAIL cksum_error c=%0d: got err=%b cpu_rst=%b busy/rdy/done=%b%b%b, want 1 00 000",
                         c, err, cpu_rst, busy, s_ready, boot_done);
            end
            step();
        end
        do_start();
        fill_big(1'b0, 1'b0, -1);
        burst_big(N, -1);
    endtask
`endif

    // Minimum image: two LOAD cycles then boot_done
    task automatic test_small_image();
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        s_valid_s = 1'b1;
        s_data_s  = 16'h1234;
        step();
        n_checks++;
        if ({s_ready_s, word_cnt_s, cpu_rst_s} !== {1'b1, CWS'(1), 2'b00}) begin
            n_fail++;
            $display("FAIL small_fill: got rdy=%b cnt=%0d cpu_rst=%b, want 1 1 00", s_ready_s, word_cnt_s, cpu_rst_s);
        end
        s_data_s = 16'habcd;
        step();
`ifdef CPU_LOADER_CKSUM_EN
        s_data_s = 16'(16'h1234 + 16'habcd);
        step();
`endif
        s_valid_s = 1'b0;
        n_checks++;
        if ({cpu_rst_s, par_s, s_ready_s} !== {2'b01, 16'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL small_load0: got cpu_rst=%b par=%h rdy=%b, want 01 1234 0", cpu_rst_s, par_s, s_ready_s);
        end
        step();
        n_checks++;
        if ({cpu_rst_s, par_s, boot_done_s} !== {2'b01, 16'habcd, 1'b0}) begin
            n_fail++;
            $display("FAIL small_load1: got cpu_rst=%b par=%h done=%b, want 01 abcd 0", cpu_rst_s, par_s, boot_done_s);
        end
        step();
        n_checks++;
        if ({cpu_rst_s, par_s, boot_done_s} !== {2'b10, 16'h8000, 1'b1}) begin
            n_fail++;
            $display("FAIL small_done: got cpu_rst=%b par=%h done=%b, want 10 8000 1", cpu_rst_s, par_s, boot_done_s);
        end
        step();
        n_checks++;
        if ({cpu_rst_s, boot_done_s, busy_s} !== {2'b10, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL small_run: got cpu_rst=%b done=%b busy=%b, want 10 0 0", cpu_rst_s, boot_done_s, busy_s);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_run_restart_stall();
        test_ignore_start();
        test_rst_mid_burst();
`ifdef CPU_LOADER_CKSUM_EN
        test_cksum_error();
`endif
        test_small_image();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
